// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus master: opcode layout, FSM encoding
// and response codes.
package periph_bus_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;
    localparam int IDX_W  = 3;

    localparam int OP_WRITE_BIT = 7;
    localparam int OP_IDX_LSB   = 4;
    localparam int OP_ADDR_LSB  = 0;

    localparam logic [7:0] OP_WRITE_MASK = 8'h80;
    localparam logic [7:0] OP_IDX_MASK   = 8'h70;
    localparam logic [7:0] OP_ADDR_MASK  = 8'h03;

    localparam logic [7:0] ACK_OK     = 8'hA5;
    localparam logic [7:0] ACK_BADSEL = 8'hE5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WLO,
        ST_WHI,
        ST_WSTB,
        ST_RSTB,
        ST_RCAP,
        ST_RSPLO,
        ST_RSPHI,
        ST_RSPACK
    } state_e;

    function automatic logic op_is_write(input logic [7:0] op);
        return op[OP_WRITE_BIT];
    endfunction

    function automatic logic [IDX_W-1:0] op_index(input logic [7:0] op);
        return op[OP_IDX_LSB +: IDX_W];
    endfunction

    function automatic logic [ADDR_W-1:0] op_addr(input logic [7:0] op);
        return op[OP_ADDR_LSB +: ADDR_W];
    endfunction

endpackage

// File: rtl/periph_bus_master.sv
// Byte-stream driven initiator for the peripheral bus: decodes read/write
// commands, issues single-cycle strobes and returns data or an acknowledge.
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int NUM_SEL        = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [7:0]                cmd_data_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    output logic [7:0]                rsp_data_o,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [NUM_SEL-1:0]        sel_o,
    output logic                      read_o,
    output logic                      write_o,
    output logic [ADDR_W-1:0]         addr_o,
    output logic [DATA_W-1:0]         data_o,
    input  logic [NUM_SEL*DATA_W-1:0] data_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  rd_buf;
    logic [CNT_W-1:0]   tcnt;

    logic               cmd_fire;
    logic               timeout_hit;
    logic [NUM_SEL-1:0] op_dec;
    logic [NUM_SEL-1:0] sel_dec;
    logic [DATA_W-1:0]  rd_slice;
    logic [7:0]         ack_byte;

    assign cmd_fire    = cmd_valid_i & cmd_ready_o;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == CNT_LAST);
    assign ack_byte    = (|sel_dec) ? ACK_OK : ACK_BADSEL;

    // Out-of-range indices decode to all zeros, which suppresses every strobe.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        op_dec   = '0;
        sel_dec  = '0;
        rd_slice = '0;
        for (int k = 0; k < NUM_SEL; k++) begin
            op_dec[k]  = (op_index(cmd_data_i) == IDX_W'(k));
            sel_dec[k] = (idx_q == IDX_W'(k));
            if (sel_dec[k]) begin
                rd_slice = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: all state and outputs are registers, so only non-blocking assignments here.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= ST_IDLE;
            idx_q       <= '0;
            rd_buf      <= '0;
            tcnt        <= '0;
            cmd_ready_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_valid_o <= 1'b0;
            sel_o       <= '0;
            read_o      <= 1'b0;
            write_o     <= 1'b0;
            addr_o      <= '0;
            data_o      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    tcnt        <= '0;
                    if (cmd_fire) begin
                        idx_q  <= op_index(cmd_data_i);
                        addr_o <= op_addr(cmd_data_i);
                        if (op_is_write(cmd_data_i)) begin
                            state <= ST_WLO;
                        end else begin
                            state       <= ST_RSTB;
                            cmd_ready_o <= 1'b0;
                            sel_o       <= op_dec;
                            read_o      <= |op_dec;
                        end
                    end
                end

                ST_WLO, ST_WHI: begin
                    if (cmd_fire) begin
                        tcnt <= '0;
                        if (state == ST_WLO) begin
                            data_o[7:0] <= cmd_data_i;
                            state       <= ST_WHI;
                        end else begin
                            data_o[15:8] <= cmd_data_i;
                            state        <= ST_WSTB;
                            cmd_ready_o  <= 1'b0;
                            sel_o        <= sel_dec;
                            write_o      <= |sel_dec;
                        end
                    end else if (timeout_hit) begin
                        // Partial command is dropped silently; ready stays high in IDLE.
                        tcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                ST_WSTB: begin
                    write_o     <= 1'b0;
                    sel_o       <= '0;
                    rsp_data_o  <= ack_byte;
                    rsp_valid_o <= 1'b1;
                    state       <= ST_RSPACK;
                end

                ST_RSTB: begin
                    read_o <= 1'b0;
                    sel_o  <= '0;
                    state  <= ST_RCAP;
                end

                // Peripherals register their read data, so it is valid one cycle after the strobe.
                ST_RCAP: begin
                    rd_buf      <= rd_slice;
                    rsp_data_o  <= rd_slice[7:0];
                    rsp_valid_o <= 1'b1;
                    state       <= ST_RSPLO;
                end

                ST_RSPLO: begin
                    if (rsp_ready_i) begin
                        rsp_data_o <= rd_buf[15:8];
                        state      <= ST_RSPHI;
                    end
                end

                ST_RSPHI, ST_RSPACK: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_data_o  <= '0;
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_master.sv
// Randomized scoreboard bench for periph_bus_master: a behavioural register
// model predicts strobes and response bytes, independent monitors compare them.
module tb_periph_bus_master;

    localparam int NS = 4;
    localparam int TO = 20;

    logic            clk_i = 1'b0;
    logic            rstn_i = 1'b0;
    logic [7:0]      cmd_data_i = '0;
    logic            cmd_valid_i = 1'b0;
    logic            cmd_ready_o;
    logic [7:0]      rsp_data_o;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic [NS-1:0]   sel_o;
    logic            read_o;
    logic            write_o;
    logic [1:0]      addr_o;
    logic [15:0]     data_o;
    logic [NS*16-1:0] data_i;

    periph_bus_master #(.NUM_SEL(NS), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .sel_o       (sel_o),
        .read_o      (read_o),
        .write_o     (write_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .data_i      (data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [NS-1:0] sel;
        logic          rd;
        logic          wr;
        logic [1:0]    addr;
        logic [15:0]   data;
    } strobe_t;

    logic [7:0] rsp_q[$];
    strobe_t    stb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         rdy_mode = 0;  // 0 random, 1 forced low, 2 forced high

    // Peripheral store (driven by the actual bus) and reference store (updated at issue).
    logic [15:0] mem     [NS][4];
    logic [15:0] ref_mem [NS][4];
    logic [15:0] pdata   [NS];

    always_comb begin
        data_i = '0;
        for (int k = 0; k < NS; k++) data_i[k*16 +: 16] = pdata[k];
    end

    always @(posedge clk_i) begin
        for (int k = 0; k < NS; k++) begin
            if (read_o && sel_o[k]) pdata[k] <= mem[k][addr_o];
            else                    pdata[k] <= 16'($urandom);
            if (write_o && sel_o[k]) mem[k][addr_o] <= data_o;
        end
    end

    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            1:       rsp_ready_i = 1'b0;
            2:       rsp_ready_i = 1'b1;
            default: rsp_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h expected=none at %0t", name, act, $time);
    endtask

    // Monitor: responses are consumed when valid&ready, strobes whenever asserted.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (rsp_valid_o && rsp_ready_i) begin
                if (rsp_q.size() == 0) fail("rsp_unexpected", 32'(rsp_data_o));
                else check("rsp_byte", 32'(rsp_data_o), 32'(rsp_q.pop_front()));
            end
            if (read_o || write_o || (|sel_o)) begin
                check("single_strobe", 32'(read_o & write_o), 32'd0);
                if (stb_q.size() == 0) begin
                    fail("strobe_unexpected", {22'd0, sel_o, read_o, write_o, addr_o});
                end else begin
                    strobe_t e;
                    e = stb_q.pop_front();
                    check("strobe_ctl", {22'd0, sel_o, read_o, write_o, addr_o},
                          {22'd0, e.sel, e.rd, e.wr, e.addr});
                    if (e.wr) check("strobe_wdata", 32'(data_o), 32'(e.data));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        cmd_data_i  = b;
        cmd_valid_i = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk_i);
            if (cmd_ready_o) break;
            n++;
        end
        if (n >= 200) fail("cmd_ready_timeout", 32'(b));
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    function automatic logic [7:0] mk_op(input logic wr, input int idx, input int addr);
        logic [1:0] rsv;
        rsv = 2'($urandom);
        return {wr, 3'(idx), rsv, 2'(addr)};
    endfunction

    function automatic logic [NS-1:0] onehot(input int idx);
        logic [NS-1:0] s;
        s = '0;
        if (idx < NS) s[idx] = 1'b1;
        return s;
    endfunction

    task automatic expect_read(input int idx, input int addr);
        logic [15:0] v;
        v = (idx < NS) ? ref_mem[idx][addr] : 16'h0000;
        if (idx < NS) stb_q.push_back('{sel: onehot(idx), rd: 1'b1, wr: 1'b0, addr: 2'(addr), data: 16'h0});
        rsp_q.push_back(v[7:0]);
        rsp_q.push_back(v[15:8]);
    endtask

    task automatic issue_read(input int idx, input int addr);
        expect_read(idx, addr);
        send_byte(mk_op(1'b0, idx, addr));
    endtask

    task automatic issue_write(input int idx, input int addr, input logic [15:0] d);
        if (idx < NS) begin
            stb_q.push_back('{sel: onehot(idx), rd: 1'b0, wr: 1'b1, addr: 2'(addr), data: d});
            ref_mem[idx][addr] = d;
            rsp_q.push_back(8'hA5);
        end else begin
            rsp_q.push_back(8'hE5);
        end
        send_byte(mk_op(1'b1, idx, addr));
        send_byte(d[7:0]);
        send_byte(d[15:8]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || stb_q.size() != 0 || rsp_valid_o) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 3000) fail("idle_timeout", 32'(rsp_q.size()));
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_rsp_valid();
        int n;
        n = 0;
        while (!rsp_valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) fail("rsp_valid_timeout", 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [7:0]  lsb;
        for (int k = 0; k < NS; k++)
            for (int a = 0; a < 4; a++) begin
                v = 16'($urandom);
                mem[k][a]     = v;
                ref_mem[k][a] = v;
            end
        mem[0][0]     = 16'h1234;
        ref_mem[0][0] = 16'h1234;
        for (int k = 0; k < NS; k++) pdata[k] = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs",
              {7'd0, cmd_ready_o, rsp_valid_o, read_o, write_o, sel_o, addr_o},
              32'd0);
        check("reset_data", {rsp_data_o, data_o}, 32'd0);
        @(negedge clk_i) rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("ready_after_reset", 32'(cmd_ready_o), 32'd1);

        // Directed read and write
        rdy_mode = 2;
        issue_read(0, 0);
        wait_idle();
        send_byte(8'h93);
        stb_q.push_back('{sel: 4'b0010, rd: 1'b0, wr: 1'b1, addr: 2'd3, data: 16'hABCD});
        rsp_q.push_back(8'hA5);
        ref_mem[1][3] = 16'hABCD;
        send_byte(8'hCD);
        send_byte(8'hAB);
        wait_idle();
        issue_read(1, 3);
        wait_idle();

        // Out-of-range selects
        issue_write(6, 1, 16'h5A5A);
        wait_idle();
        issue_read(5, 2);
        wait_idle();

        // Response backpressure: byte held, no new command accepted
        rdy_mode = 1;
        @(posedge clk_i);
        #1;
        lsb = ref_mem[2][1][7:0];
        issue_read(2, 1);
        wait_rsp_valid();
        cmd_data_i  = mk_op(1'b0, 3, 0);
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("hold_data", 32'(rsp_data_o), 32'(lsb));
            check("hold_valid_noready", {30'd0, rsp_valid_o, cmd_ready_o}, 32'd2);
        end
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        rdy_mode = 0;
        wait_idle();

        // Timeout boundary: gap just under the limit still completes
        rdy_mode = 2;
        stb_q.push_back('{sel: 4'b0001, rd: 1'b0, wr: 1'b1, addr: 2'd1, data: 16'hBEEF});
        rsp_q.push_back(8'hA5);
        ref_mem[0][1] = 16'hBEEF;
        send_byte(mk_op(1'b1, 0, 1));
        send_byte(8'hEF);
        repeat (TO - 3) @(posedge clk_i);
        #1;
        send_byte(8'hBE);
        wait_idle();

        // Timeout expiry: partial write discarded, following read is normal
        send_byte(mk_op(1'b1, 1, 2));
        send_byte(8'h77);
        repeat (TO + 3) @(posedge clk_i);
        #1;
        check("timeout_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        issue_read(1, 2);
        wait_idle();

        // Randomized traffic
        rdy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            int idx;
            int addr;
            idx  = int'($urandom_range(0, 7));
            addr = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) issue_write(idx, addr, 16'($urandom));
            else                           issue_read(idx, addr);
        end
        wait_idle();

        // Asynchronous reset while presenting the MSB
        rdy_mode = 1;
        @(posedge clk_i);
        #1;
        issue_read(2, 0);
        wait_rsp_valid();
        rdy_mode = 2;
        @(posedge clk_i);
        #2 rdy_mode = 1;
        @(posedge clk_i);
        #3 rstn_i = 1'b0;
        #1;
        check("async_reset_ctl",
              {7'd0, cmd_ready_o, rsp_valid_o, read_o, write_o, sel_o, addr_o},
              32'd0);
        check("async_reset_data", {rsp_data_o, data_o}, 32'd0);
        rsp_q.delete();
        stb_q.delete();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("ready_after_async_reset", 32'(cmd_ready_o), 32'd1);
        rdy_mode = 0;
        issue_read(3, 3);
        wait_idle();

        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("stb_queue_drained", 32'(stb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Initiator side of the on-chip peripheral bus (sel/read/write/addr/data) used by the MCU peripherals, e.g. the 32-bit timer.
- Accepts a byte-stream command channel (valid/ready), typically fed by a UART/debug receiver, and issues single read or write accesses to up to NUM_SEL peripherals.
- Returns read data or a write acknowledge on a byte-stream response channel.
- Lets a host exercise and debug peripherals without the CPU.

Parameters:
- NUM_SEL, 4: number of peripheral selects; valid range 1..8.
- TIMEOUT_CYCLES, 1000: idle cycles allowed between write-command bytes before the partial command is discarded; 0 disables the timeout.

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  reset, asynchronous, active-low
- cmd_data_i  input  8  command byte
- cmd_valid_i  input  1  command byte valid
- cmd_ready_o  output  1  command byte accepted when valid&ready
- rsp_data_o  output  8  response byte
- rsp_valid_o  output  1  response byte valid
- rsp_ready_i  input  1  response byte consumed when valid&ready
- sel_o  output  NUM_SEL  one-hot peripheral select
- read_o  output  1  read strobe
- write_o  output  1  write strobe
- addr_o  output  2  register address
- data_o  output  16  write data
- data_i  input  NUM_SEL*16  read data; peripheral k occupies bits [16k+15:16k]

Behaviour:
- Opcode byte fields:
  - bit7: 1=write, 0=read
  - bits6:4: peripheral index
  - bits3:2: reserved, ignored
  - bits1:0: addr
- Write command: opcode, data LSB byte, data MSB byte. Read command: opcode only.
- FSM states: IDLE, WLO, WHI, WSTB, RSTB, RCAP, RSPLO, RSPHI, RSPACK. Reset state is IDLE.
- cmd_ready_o=1 only in IDLE, WLO and WHI.
- IDLE: on an accepted opcode, latch index/addr. Write goes to WLO; read goes to RSTB.
- WLO: accepted byte goes to data_o[7:0], then WHI. WHI: accepted byte goes to data_o[15:8], then WSTB.
- WSTB (exactly one cycle):
  - write_o=1, sel_o=one-hot(index), addr_o/data_o stable.
  - Next state RSPACK; rsp_data_o=8'hA5.
- RSTB (exactly one cycle): read_o=1, sel_o=one-hot(index), addr_o stable. Next state RCAP.
- RCAP: peripherals present registered read data the cycle after the read strobe.
  - Sample data_i slice[index] into a 16-bit buffer; strobes are 0.
  - Next state RSPLO.
- RSPLO presents buf[7:0]; RSPHI presents buf[15:8]; RSPACK presents the ack byte. All three hold rsp_valid_o=1.
- Each response state advances on rsp_ready_i: RSPLO to RSPHI, RSPHI and RSPACK to IDLE.
- rsp_data_o and rsp_valid_o are held stable while rsp_valid_o&~rsp_ready_i.
- Latency:
  - Read opcode accepted in cycle 0: read_o in cycle 1, rsp_valid_o with LSB in cycle 3.
  - Write MSB accepted in cycle N: write_o in cycle N+1, ack valid in cycle N+2.
- Strobes (sel_o, read_o, write_o) are registered outputs, glitch-free, asserted only in WSTB/RSTB. At most one strobe is active per cycle.
- Out-of-range index (>= NUM_SEL):
  - No strobe, sel_o stays 0.
  - Read returns 16'h0000 (bytes 00,00).
  - Write returns ack byte 8'hE5 instead of A5.
- Timeout: in WLO/WHI, a counter increments each cycle without an accepted byte and resets on acceptance.
  - Reaching TIMEOUT_CYCLES: go to IDLE, discard the partial command, no strobe, no response.
  - No timeout applies while waiting on rsp_ready_i.
- Asynchronous reset at any point: go to IDLE. Outputs reset to 0: sel_o, read_o, write_o, addr_o, data_o, rsp_data_o, rsp_valid_o, cmd_ready_o. The read buffer and timeout counter clear; any in-flight command is lost.
- Commands are strictly serialized; no new opcode is accepted until the response completes.

Decomposition:
- Package periph_bus_pkg holds:
  - opcode field positions/masks
  - FSM state encoding
  - ACK_OK=8'hA5, ACK_BADSEL=8'hE5
  - peripheral data width 16
  - address width 2
- No sub-module; the timeout counter and read-data mux are inline.

Test Plan:
- Read index 0 addr 0 with peripheral 0 model returning 16'h1234 one cycle after read_o -> single-cycle read_o with sel_o=4'b0001, addr_o=0; responses 8'h34 then 8'h12.
- Write opcode 8'h93 then bytes 8'hCD, 8'hAB -> one cycle with write_o=1, sel_o=4'b0010, addr_o=3, data_o=16'hABCD; response 8'hA5.
- Write index 6 (NUM_SEL=4) -> no strobe ever, response 8'hE5; read index 5 -> responses 00,00.
- rsp_ready_i low for 10 cycles during a read response -> rsp_data_o held at the LSB, no new command accepted; proceeds on ready.
- Write opcode + one data byte, then silence for TIMEOUT_CYCLES -> return to IDLE, no write_o, no response. The next read command completes normally.
- Assert rstn_i low during RSPHI -> all outputs 0 immediately. After release, cmd_ready_o=1 and a fresh read works.
